fb_port_arbiter: RTL and testbench

Shares one single-port framebuffer RAM between two requesters: the scanout fetch path that feeds pixelgen, and a pixel writer (pattern/drawing engine).
- Scanout has absolute priority and a fixed read latency, so video timing from the timer never stalls.
- Writer transactions are buffered in a small FIFO and retired only on cycles with no scanout request, mostly during blanking.
- Sits between the timer-driven fetch logic and the RAM, clocked by VGA_CLK.

---
 rtl/fb_pkg.sv | 32 +++
 rtl/fb_wr_fifo.sv | 57 +++++
 rtl/fb_port_arbiter.sv | 134 +++++++++++++
 tb/tb_fb_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types for the framebuffer port arbiter: write FIFO entry, access
// decision encoding and the priority rule between scanout and writer.
package fb_pkg;

    localparam int FB_ADDR_W = 16;
    localparam int FB_DATA_W = 24;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_wr_t;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } fb_acc_e;

    // Scanout always wins; buffered writes only use otherwise idle cycles.
    function automatic fb_acc_e fb_arbitrate(input logic scan_req,
                                             input logic wr_pending);
        fb_acc_e acc;
        acc = ACC_IDLE;
        if (scan_req) begin
            acc = ACC_READ;
        end else if (wr_pending) begin
            acc = ACC_WRITE;
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO of writer transactions with full/empty flags.
// Pointers carry an extra wrap bit so full and empty need no counter.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  fb_wr_t push_entry,
    input  logic   pop,
    output fb_wr_t head,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fb_wr_t           entries [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr[PTR_W-1:0]];

    // NOTE: the entry storage is deliberately not reset; an entry is only
    // ever read after it was written, and leaving it out of reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr[PTR_W-1:0]] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares one single-port framebuffer RAM between the scanout fetch path
// (absolute priority, fixed read latency) and a FIFO-buffered pixel writer.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_pending,
    output logic [15:0]       stall_cnt
);

    fb_wr_t              push_entry;
    fb_wr_t              head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                ready_q;
    logic                push;
    logic                pop;
    fb_acc_e             acc_d;
    fb_acc_e             acc_q;
    logic [RD_LAT-1:0]   vld_sr;

    // ready_q keeps wr_ready low while reset is held and for the release edge.
    assign wr_ready   = ready_q && !fifo_full;
    assign push       = wr_valid && wr_ready;
    assign wr_pending = !fifo_empty;
    assign acc_d      = fb_arbitrate(scan_req, !fifo_empty);
    assign pop        = (acc_d == ACC_WRITE);

    // NOTE: combinational blocks assign every output first, so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        push_entry      = '0;
        push_entry.addr = FB_ADDR_W'(wr_addr);
        push_entry.data = FB_DATA_W'(wr_data);
    end

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Registered RAM drive; address and data hold on idle cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= ACC_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            acc_q <= acc_d;
            unique case (acc_d)
                ACC_READ: begin
                    mem_addr <= scan_addr;
                end
                ACC_WRITE: begin
                    mem_addr  <= ADDR_W'(head.addr);
                    mem_wdata <= DATA_W'(head.data);
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_en = (acc_q != ACC_IDLE);
    assign mem_we = (acc_q == ACC_WRITE);

    // In-flight reads: one bit per cycle of RAM latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= scan_req;
            for (int i = RD_LAT - 1; i >= 1; i--) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_valid <= 1'b0;
            scan_data  <= '0;
        end else begin
            scan_valid <= vld_sr[RD_LAT-1];
            if (vld_sr[RD_LAT-1]) begin
                scan_data <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (scan_req && !fifo_empty && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomized bench for fb_port_arbiter against a queue-based transaction model
// and a behavioural RAM attached to the memory port.
module tb_fb_port_arbiter;
    import fb_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 24;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              scan_req = 1'b0;
    logic [ADDR_W-1:0] scan_addr = '0;
    logic              scan_valid;
    logic [DATA_W-1:0] scan_data;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              wr_pending;
    logic [15:0]       stall_cnt;

    always #5 clk = ~clk;

    fb_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_req   (scan_req),
        .scan_addr  (scan_addr),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wr_pending (wr_pending),
        .stall_cnt  (stall_cnt)
    );

    // Behavioural RAM: one registered output stage gives RD_LAT=2 end to end.
    logic [DATA_W-1:0] ram     [0:65535];
    bit                ram_wr  [0:65535];
    logic [DATA_W-1:0] rdata_q;

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return (a == 16'h0010) ? 24'hABCDEF : {8'h5A, a};
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end else begin
                rdata_q <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            end
        end
    end
    assign mem_rdata = rdata_q;

    // Reference model state.
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } rd_t;

    int                total = 0;
    int                bad   = 0;
    int                cyc   = 0;
    rd_t               rdq[$];
    fb_wr_t            wq[$];
    logic [DATA_W-1:0] gold[int];
    bit                m_ready = 1'b0;
    int                m_stall = 0;
    bit                m_en = 1'b0;
    bit                m_we = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [DATA_W-1:0] m_sdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] gold_rd(input logic [ADDR_W-1:0] a);
        return gold.exists(int'(a)) ? gold[int'(a)] : init_val(a);
    endfunction

    // One clock cycle: check outputs, drive inputs, advance the model.
    task automatic step(input bit rst, input bit sreq, input logic [ADDR_W-1:0] saddr,
                        input bit wv, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] wd, output bit accepted);
        bit     exp_sv;
        bit     exp_rdy;
        fb_wr_t e;
        @(negedge clk);
        cyc++;
        exp_sv = (rdq.size() > 0) && (rdq[0].due == cyc);
        if (exp_sv) begin
            m_sdata = rdq[0].data;
            void'(rdq.pop_front());
        end
        exp_rdy = m_ready && (wq.size() < DEPTH);
        check("scan_valid", 32'(scan_valid), 32'(exp_sv));
        check("scan_data",  32'(scan_data),  32'(m_sdata));
        check("wr_ready",   32'(wr_ready),   32'(exp_rdy));
        check("wr_pending", 32'(wr_pending), 32'(wq.size() != 0));
        check("stall_cnt",  32'(stall_cnt),  32'(m_stall));
        check("mem_en",     32'(mem_en),     32'(m_en));
        check("mem_we",     32'(mem_we),     32'(m_we));
        check("mem_addr",   32'(mem_addr),   32'(m_addr));
        check("mem_wdata",  32'(mem_wdata),  32'(m_wdata));

        reset_n   = !rst;
        scan_req  = sreq;
        scan_addr = saddr;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        accepted  = 1'b0;

        if (rst) begin
            rdq.delete();
            wq.delete();
            m_ready = 1'b0;
            m_stall = 0;
            m_en    = 1'b0;
            m_we    = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
            m_sdata = '0;
        end else begin
            // The access on the port this cycle completes at the coming edge.
            if (m_en && m_we) begin
                gold[int'(m_addr)] = m_wdata;
            end else if (m_en) begin
                rdq.push_back('{cyc + RD_LAT, gold_rd(m_addr)});
            end
            if (sreq && (wq.size() > 0) && (m_stall < 65535)) begin
                m_stall++;
            end
            if (sreq) begin
                m_en   = 1'b1;
                m_we   = 1'b0;
                m_addr = saddr;
            end else if (wq.size() > 0) begin
                e       = wq.pop_front();
                m_en    = 1'b1;
                m_we    = 1'b1;
                m_addr  = e.addr;
                m_wdata = e.data;
            end else begin
                m_en = 1'b0;
                m_we = 1'b0;
            end
            if (wv && exp_rdy) begin
                wq.push_back('{wa, wd});
                accepted = 1'b1;
            end
            m_ready = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, '0, 1'b0, '0, '0, acc);
        end
    endtask

    task automatic random_phase(input int n, input int scan_pct, input int wr_pct);
        bit acc;
        for (int i = 0; i < n; i++) begin
            step(1'b0, ($urandom_range(0, 99) < scan_pct), 16'($urandom_range(0, 63)),
                 ($urandom_range(0, 99) < wr_pct), 16'($urandom_range(0, 63)),
                 24'($urandom), acc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int k;

        // Reset held, then idle scanout and writer.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, '0, '0, acc);
        idle(20);

        // Single scanout read of a preloaded word.
        step(1'b0, 1'b1, 16'h0010, 1'b0, '0, '0, acc);
        idle(6);

        // Scanout held for 8 cycles while the writer offers 6 words.
        k = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 16'(i), (k < 6), 16'(32 + k), 24'(32'h200 + k), acc);
            if (acc) k++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, '0, (k < 6), 16'(32 + k), 24'(32'h200 + k), acc);
            if (acc) k++;
        end
        check("starved_accepts", 32'(k), 32'd6);

        // Writer streams 10 words with scanout idle.
        k = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, '0, (k < 10), 16'(k), 24'(32'h100 + k), acc);
            if (acc) k++;
        end
        check("stream_accepts", 32'(k), 32'd10);

        // Fill to DEPTH-1, then push and pop together every cycle.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'(i), 1'b1, 16'(48 + i), 24'(32'h300 + i), acc);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, 16'(50 + i), 24'(32'h400 + i), acc);
        end
        idle(8);

        random_phase(1500, 40, 50);
        random_phase(500, 85, 80);
        idle(10);

        // Reset with 3 writes pending and 2 reads in flight.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'(i), 1'b1, 16'(40 + i), 24'(32'hDEAD00 + i), acc);
        end
        step(1'b0, 1'b1, 16'h0010, 1'b0, '0, '0, acc);
        step(1'b0, 1'b1, 16'h0011, 1'b0, '0, '0, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, '0, '0, acc);
        idle(10);

        random_phase(600, 30, 60);
        idle(12);

        for (int a = 0; a < 64; a++) begin
            check("ram_contents", 32'(ram_wr[a] ? ram[a] : init_val(16'(a))), 32'(gold_rd(16'(a))));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
